// File: rtl/dma_pkg.sv
// Shared DMA definitions: bus size codes, address modes, channel FSM states,
// and small helpers for address alignment, stepping and halfword lane packing.
package dma_pkg;

  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  localparam logic [1:0] DMA_ADDR_INC        = 2'b00;
  localparam logic [1:0] DMA_ADDR_DEC        = 2'b01;
  localparam logic [1:0] DMA_ADDR_FIXED      = 2'b10;
  localparam logic [1:0] DMA_ADDR_INC_RELOAD = 2'b11;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_WAIT_GNT,
    DMA_RD_A,
    DMA_WR_A,
    DMA_LAST_D
  } dma_state_t;

  function automatic logic [31:0] dma_align(input logic [31:0] addr, input logic word);
    return word ? {addr[31:2], 2'b00} : {addr[31:1], 1'b0};
  endfunction

  function automatic logic [31:0] dma_step(input logic word);
    return word ? 32'd4 : 32'd2;
  endfunction

  // Halfword units take the lane selected by the source address and
  // replicate it so the destination lane does not matter to the bus.
  function automatic logic [31:0] dma_pack_wdata(input logic [31:0] rdata,
                                                 input logic        word,
                                                 input logic        upper);
    logic [15:0] half;
    half = upper ? rdata[31:16] : rdata[15:0];
    return word ? rdata : {half, half};
  endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// One DMA address generator (source or destination).
// Ports:
//   clock, reset - system clock, synchronous active-high reset
//   load         - latch base/word/mode (aligned) for a new transfer
//   base         - start address from configuration
//   word         - 1 = 4-byte units, 0 = 2-byte units
//   mode         - inc / dec / fixed / inc-reload
//   step         - advance after an accepted address phase
//   addr         - current address
module dma_addr_gen
  import dma_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] base,
  input  logic        word,
  input  logic [1:0]  mode,
  input  logic        step,
  output logic [31:0] addr
);

  logic       word_q;
  logic [1:0] mode_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr   <= '0;
      word_q <= 1'b0;
      mode_q <= DMA_ADDR_INC;
    end else if (load) begin
      addr   <= dma_align(base, word);
      word_q <= word;
      mode_q <= mode;
    end else if (step) begin
      case (mode_q)
        DMA_ADDR_DEC:   addr <= addr - dma_step(word_q);
        DMA_ADDR_FIXED: addr <= addr;
        default:        addr <= addr + dma_step(word_q);
      endcase
    end
  end

endmodule

// File: rtl/dma_channel.sv
// Single DMA channel: copies halfword/word units from source to destination
// over the pipelined memory bus (address phase N, data phase N+1).
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   cfg_*               - transfer configuration, sampled on accepted start
//   start               - one-cycle request, honoured only when idle
//   busy, done          - transfer in progress / one-cycle completion pulse
//   bus_req, bus_grant  - arbiter handshake
//   bus_addr/size/write - address phase outputs
//   bus_wdata           - write data (data phase)
//   bus_rdata           - read data (data phase)
//   bus_pause           - stall, current cycle not accepted
module dma_channel
  import dma_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 14
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          cfg_src,
  input  logic [31:0]          cfg_dst,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  input  logic                 cfg_word,
  input  logic [1:0]           cfg_src_mode,
  input  logic [1:0]           cfg_dst_mode,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 bus_req,
  input  logic                 bus_grant,
  output logic [31:0]          bus_addr,
  output logic [1:0]           bus_size,
  output logic                 bus_write,
  output logic [31:0]          bus_wdata,
  input  logic [31:0]          bus_rdata,
  input  logic                 bus_pause
);

  localparam logic [CNT_WIDTH:0] CNT_ONE  = {{CNT_WIDTH{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH:0] CNT_FULL = {1'b1, {CNT_WIDTH{1'b0}}};

  dma_state_t         state;
  logic [CNT_WIDTH:0] remaining;
  logic [31:0]        src_addr;
  logic [31:0]        dst_addr;
  logic [31:0]        rd_addr;   // address of the most recent source read
  logic               word_q;
  logic               load;
  logic               src_step;
  logic               dst_step;

  // Bus outputs are registered for the state being entered, so each
  // generator steps on the same edge that copies its address onto the bus.
  always_comb begin
    load     = (state == DMA_IDLE) && start;
    src_step = 1'b0;
    dst_step = 1'b0;
    if (!bus_pause) begin
      case (state)
        DMA_WAIT_GNT: src_step = bus_grant;
        DMA_RD_A:     dst_step = bus_grant;
        DMA_WR_A:     src_step = (remaining != CNT_ONE);
        default:      ;
      endcase
    end
  end

  dma_addr_gen u_src (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .base  (cfg_src),
    .word  (cfg_word),
    .mode  (cfg_src_mode),
    .step  (src_step),
    .addr  (src_addr)
  );

  dma_addr_gen u_dst (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .base  (cfg_dst),
    .word  (cfg_word),
    .mode  (cfg_dst_mode),
    .step  (dst_step),
    .addr  (dst_addr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= DMA_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bus_req   <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_size  <= MEM_SIZE_HALF;
      bus_wdata <= '0;
      remaining <= '0;
      rd_addr   <= '0;
      word_q    <= 1'b0;
    end else begin
      case (state)
        DMA_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= DMA_WAIT_GNT;
            busy      <= 1'b1;
            bus_req   <= 1'b1;
            bus_write <= 1'b0;
            word_q    <= cfg_word;
            bus_size  <= cfg_word ? MEM_SIZE_WORD : MEM_SIZE_HALF;
            // Waiting for grant looks like a harmless read of the first source.
            bus_addr  <= dma_align(cfg_src, cfg_word);
            remaining <= (cfg_count == '0) ? CNT_FULL : {1'b0, cfg_count};
          end
        end

        DMA_WAIT_GNT: begin
          if (!bus_pause && bus_grant) begin
            state    <= DMA_RD_A;
            bus_addr <= src_addr;
            rd_addr  <= src_addr;
          end
        end

        DMA_RD_A: begin
          if (!bus_pause && bus_grant) begin
            state     <= DMA_WR_A;
            bus_addr  <= dst_addr;
            bus_write <= 1'b1;
          end
        end

        DMA_WR_A: begin
          if (!bus_pause) begin
            bus_wdata <= dma_pack_wdata(bus_rdata, word_q, rd_addr[1]);
            remaining <= remaining - CNT_ONE;
            bus_write <= 1'b0;
            if (remaining == CNT_ONE) begin
              state    <= DMA_LAST_D;
              bus_addr <= rd_addr;
            end else begin
              state    <= DMA_RD_A;
              bus_addr <= src_addr;
              rd_addr  <= src_addr;
            end
          end
        end

        DMA_LAST_D: begin
          if (!bus_pause) begin
            state   <= DMA_IDLE;
            done    <= 1'b1;
            busy    <= 1'b0;
            bus_req <= 1'b0;
          end
        end

        default: state <= DMA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_channel.sv
module tb_dma_channel;
  import dma_pkg::*;

  logic        clock;
  logic        reset;
  logic [31:0] cfg_src;
  logic [31:0] cfg_dst;
  logic [3:0]  cfg_count;
  logic        cfg_word;
  logic [1:0]  cfg_src_mode;
  logic [1:0]  cfg_dst_mode;
  logic        start;
  logic        busy;
  logic        done;
  logic        bus_req;
  logic        bus_grant;
  logic [31:0] bus_addr;
  logic [1:0]  bus_size;
  logic        bus_write;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_pause;

  dma_channel #(.CNT_WIDTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_src      (cfg_src),
    .cfg_dst      (cfg_dst),
    .cfg_count    (cfg_count),
    .cfg_word     (cfg_word),
    .cfg_src_mode (cfg_src_mode),
    .cfg_dst_mode (cfg_dst_mode),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .bus_req      (bus_req),
    .bus_grant    (bus_grant),
    .bus_addr     (bus_addr),
    .bus_size     (bus_size),
    .bus_write    (bus_write),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_pause    (bus_pause)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [31:0] mem [bit [31:0]];
  logic        pend_wr = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [1:0]  pend_size = '0;
  int          writes = 0;
  int          src_moved = 0;
  logic        track_src = 1'b0;
  logic [31:0] track_addr = '0;
  int          grant_viol = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a)
      32'h0300_0000: return 32'hdead_beef;
      32'h0300_0004: return 32'hcafe_f00d;
      32'h0300_0008: return 32'hba5e_ba11;
      32'h0300_000c: return 32'hc0ff_ee55;
      32'h0300_1234: return 32'h5ece_de00;
      32'h0500_0000: return 32'h3333_4444;
      32'h0500_0004: return 32'h1111_2222;
      32'h0700_0004: return 32'haaaa_0000;
      default:       return a ^ 32'h5a5a_5a5a;
    endcase
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return mem.exists(k) ? mem[k] : init_word(k);
  endfunction

  initial bus_rdata = '0;

  always @(posedge clock) begin
    logic [31:0] old;
    logic [31:0] k;
    if (reset) begin
      pend_wr <= 1'b0;
    end else if (!bus_pause) begin
      if (pend_wr) begin
        k   = {pend_addr[31:2], 2'b00};
        old = mem_rd(k);
        if (pend_size == MEM_SIZE_WORD) mem[k] = bus_wdata;
        else if (pend_addr[1])          mem[k] = {bus_wdata[31:16], old[15:0]};
        else                            mem[k] = {old[31:16], bus_wdata[15:0]};
        writes <= writes + 1;
      end
      pend_wr   <= bus_grant && bus_write;
      pend_addr <= bus_addr;
      pend_size <= bus_size;
      if (bus_grant && !bus_write) begin
        bus_rdata <= mem_rd(bus_addr);
        if (track_src && bus_addr != track_addr) src_moved <= src_moved + 1;
      end
    end
  end

  // Arbiter rule: the grant may only drop while the channel is in RD_A.
  always @(negedge clock) begin
    if (!reset && (dut.state == DMA_WR_A || dut.state == DMA_LAST_D) && !bus_grant)
      grant_viol <= grant_viol + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [3:0] n,
                      input logic w, input logic [1:0] sm, input logic [1:0] dm);
    cfg_src = s; cfg_dst = d; cfg_count = n; cfg_word = w;
    cfg_src_mode = sm; cfg_dst_mode = dm;
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  // Latency counted in clocks from the first WAIT_GNT cycle to the cycle
  // where done is visible: 1 (grant seen) + 2N+1 (+ stalls).
  task automatic wait_done(input string tag, input int exp);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, cyc - t0, exp);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int extra;
    int w0;
    reset = 1'b1; start = 1'b0; bus_pause = 1'b0; bus_grant = 1'b1;
    cfg_src = 32'h0300_0000; cfg_dst = 32'h0600_0000; cfg_count = 4'd1;
    cfg_word = 1'b1; cfg_src_mode = DMA_ADDR_INC; cfg_dst_mode = DMA_ADDR_INC;
    tick();
    start = 1'b1;                      // reset wins over a simultaneous start
    tick();
    start = 1'b0;
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_done",  {31'd0, done},      32'd0);
    check("rst_req",   {31'd0, bus_req},   32'd0);
    check("rst_write", {31'd0, bus_write}, 32'd0);
    check("rst_addr",  bus_addr,           32'd0);
    check("rst_size",  {30'd0, bus_size},  {30'd0, MEM_SIZE_HALF});
    check("rst_wdata", bus_wdata,          32'd0);
    reset = 1'b0;
    tick();
    check("rst_start_ignored", {31'd0, busy}, 32'd0);

    // 1: word copy, 4 units
    kick(32'h0300_0000, 32'h0600_0000, 4'd4, 1'b1, DMA_ADDR_INC, DMA_ADDR_INC);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_req",  {31'd0, bus_req}, 32'd1);
    wait_done("t1", 10);
    check("t1_w0", mem_rd(32'h0600_0000), 32'hdead_beef);
    check("t1_w1", mem_rd(32'h0600_0004), 32'hcafe_f00d);
    check("t1_w2", mem_rd(32'h0600_0008), 32'hba5e_ba11);
    check("t1_w3", mem_rd(32'h0600_000c), 32'hc0ff_ee55);

    // 2: halfword, decrementing source
    kick(32'h0500_0006, 32'h0700_0000, 4'd3, 1'b0, DMA_ADDR_DEC, DMA_ADDR_INC);
    check("t2_size", {30'd0, bus_size}, {30'd0, MEM_SIZE_HALF});
    wait_done("t2", 8);
    check("t2_h01", mem_rd(32'h0700_0000), 32'h2222_1111);
    check("t2_h2",  mem_rd(32'h0700_0004), 32'haaaa_3333);

    // 3: fixed-source fill
    kick(32'h0300_1234, 32'h0600_0000, 4'd8, 1'b1, DMA_ADDR_FIXED, DMA_ADDR_INC);
    track_addr = 32'h0300_1234;
    track_src  = 1'b1;
    wait_done("t3", 18);
    track_src = 1'b0;
    check("t3_src_fixed", src_moved, 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("t3_w%0d", i), mem_rd(32'h0600_0000 + 32'(4 * i)), 32'h5ece_de00);

    // 4: pauses in WR_A (3) and LAST_D (2)
    kick(32'h0300_0000, 32'h0600_0100, 4'd2, 1'b1, DMA_ADDR_INC, DMA_ADDR_INC);
    tick();                            // RD_A
    tick();                            // WR_A
    check("t4_wr_write", {31'd0, bus_write}, 32'd1);
    bus_pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t4_p%0d_addr", i), bus_addr, 32'h0600_0100);
      check($sformatf("t4_p%0d_write", i), {31'd0, bus_write}, 32'd1);
    end
    bus_pause = 1'b0;
    tick();                            // RD_A
    tick();                            // WR_A
    tick();                            // LAST_D
    check("t4_last_write", {31'd0, bus_write}, 32'd0);
    check("t4_last_addr",  bus_addr, 32'h0300_0004);
    bus_pause = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("t4_l%0d_wdata", i), bus_wdata, 32'hcafe_f00d);
      check($sformatf("t4_l%0d_done", i), {31'd0, done}, 32'd0);
      check($sformatf("t4_l%0d_busy", i), {31'd0, busy}, 32'd1);
    end
    bus_pause = 1'b0;
    wait_done("t4", 11);
    check("t4_w0", mem_rd(32'h0600_0100), 32'hdead_beef);
    check("t4_w1", mem_rd(32'h0600_0104), 32'hcafe_f00d);

    // 5: count 0 -> 16 units, ignored start mid-transfer
    kick(32'h0300_2000, 32'h0600_0200, 4'd0, 1'b1, DMA_ADDR_INC, DMA_ADDR_INC_RELOAD);
    repeat (10) tick();
    cfg_dst = 32'h0600_0400; cfg_count = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_busy_mid", {31'd0, busy}, 32'd1);
    wait_done("t5", 34);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) extra++;
    end
    check("t5_no_second_done", extra, 32'd0);
    for (int i = 0; i < 16; i++)
      check($sformatf("t5_w%0d", i), mem_rd(32'h0600_0200 + 32'(4 * i)),
            (32'h0300_2000 + 32'(4 * i)) ^ 32'h5a5a_5a5a);
    check("t5_w16_untouched", mem_rd(32'h0600_0240), 32'h0600_0240 ^ 32'h5a5a_5a5a);
    check("t5_ignored_dst",   mem_rd(32'h0600_0400), 32'h0600_0400 ^ 32'h5a5a_5a5a);

    // 6: reset during third WR_A of an 8-unit copy
    w0 = writes;
    kick(32'h0300_3100, 32'h0600_0300, 4'd8, 1'b1, DMA_ADDR_INC, DMA_ADDR_INC);
    repeat (6) tick();
    check("t6_wr3_write", {31'd0, bus_write}, 32'd1);
    check("t6_wr3_addr",  bus_addr, 32'h0600_0308);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_busy",  {31'd0, busy},      32'd0);
    check("t6_req",   {31'd0, bus_req},   32'd0);
    check("t6_write", {31'd0, bus_write}, 32'd0);
    check("t6_writes_at_reset", writes - w0, 32'd2);
    repeat (10) tick();
    check("t6_writes_after", writes - w0, 32'd2);
    check("t6_w0", mem_rd(32'h0600_0300), 32'h0300_3100 ^ 32'h5a5a_5a5a);
    check("t6_w1", mem_rd(32'h0600_0304), 32'h0300_3104 ^ 32'h5a5a_5a5a);
    check("t6_w2_untouched", mem_rd(32'h0600_0308), 32'h0600_0308 ^ 32'h5a5a_5a5a);

    // restart, with grant withdrawn for two cycles in RD_A
    kick(32'h0300_3000, 32'h0600_0380, 4'd2, 1'b1, DMA_ADDR_INC, DMA_ADDR_INC);
    tick();                            // RD_A
    bus_grant = 1'b0;
    tick();
    check("t6_nogrant_write", {31'd0, bus_write}, 32'd0);
    check("t6_nogrant_addr",  bus_addr, 32'h0300_3000);
    tick();
    bus_grant = 1'b1;
    wait_done("t6r", 8);
    check("t6r_w0", mem_rd(32'h0600_0380), 32'h0300_3000 ^ 32'h5a5a_5a5a);
    check("t6r_w1", mem_rd(32'h0600_0384), 32'h0300_3004 ^ 32'h5a5a_5a5a);

    check("grant_held_in_wr_last", grant_viol, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
